// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with separate request and response valid/ready channels.
// Optional macro DMEM_ALIGN_CHECK_EN reports misaligned byte addresses as access errors.
module dmem_responder #(
    parameter int          ADDR_W_WORDS = 10,
    parameter int          WAIT_CYCLES  = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << ADDR_W_WORDS;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The requester may hold valid low indefinitely. While rsp_valid is high, the responder
    // holds rsp_rdata and rsp_err stable until the response is taken.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_commit;
    logic [31:0]             w_off;
    logic                    w_oob;
    logic                    w_err;
    logic [ADDR_W_WORDS-1:0] w_idx;

    assign req_ready = reset && (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd0);

    assign w_off = r_addr - BASE_ADDR;
    assign w_oob = (r_addr < BASE_ADDR) || (w_off >= 32'(4 << ADDR_W_WORDS));
    assign w_idx = w_off[ADDR_W_WORDS+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = w_oob || (r_addr[1:0] != 2'b00);
`else
    assign w_err = w_oob;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

    // Storage is intentionally not reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // WAIT always lasts WAIT_CYCLES+1 cycles, so rsp_valid rises 1+WAIT_CYCLES edges after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (r_we || w_err) ? 32'd0 : r_mem[w_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases followed by random traffic
// compared against a word-array reference model.
module tb_dmem_responder;

    localparam int          W     = 2;
    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam longint      BYTES = longint'(4) << AW;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] ref_mem [int];

    dmem_responder #(
        .ADDR_W_WORDS(AW),
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed range/alignment rules applied to a word array.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, output logic [31:0] rd, output logic err);
        longint off;
        int     w;
        logic [31:0] word;
        off = longint'(addr) - longint'(BASE);
        err = (off < 0) || (off >= BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr % 4 != 0) err = 1'b1;
`endif
        rd = 32'd0;
        if (!err) begin
            w    = int'(off / 4);
            word = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
                end
                ref_mem[w] = word;
            end else begin
                rd = word;
            end
        end
    endfunction

    // Driver: one full transaction; the response is held for `hold` cycles of rsp_ready=0.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] obs_rd, output logic obs_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        model(we, addr, wdata, be, exp_rd, exp_err);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(W + 1));
        obs_rd  = rsp_rdata;
        obs_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", 32'(rsp_err), 32'(exp_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          wd;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;

        // Prefill the words used by random traffic so every load has a known value.
        for (int i = 0; i < 64; i++) begin
            txn(1'b1, BASE + 32'(i * 4), $urandom, 4'b1111, 0, rd, er);
        end

        // Store/load round trip
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, rd, er);
        chk("st_rdata_zero", rd, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'b0000, 0, rd, er);
        chk("rt_rdata", rd, 32'hDEADBEEF);
        chk("rt_err", 32'(er), 32'd0);

        // Byte enables
        txn(1'b1, 32'h20, 32'h11223344, 4'b1111, 0, rd, er);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er);
        txn(1'b0, 32'h20, 32'd0, 4'b0000, 0, rd, er);
        chk("be_merge", rd, 32'h11BB33DD);
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er);
        chk("be_none_err", 32'(er), 32'd0);
        txn(1'b0, 32'h20, 32'd0, 4'b1111, 0, rd, er);
        chk("be_none_data", rd, 32'h11BB33DD);

        // Backpressure
        txn(1'b0, 32'h10, 32'd0, 4'b0000, 10, rd, er);
        chk("bp_rdata", rd, 32'hDEADBEEF);

        // Range
        txn(1'b1, BASE, 32'hCAFEF00D, 4'b1111, 0, rd, er);
        txn(1'b0, BASE + 32'd4096, 32'd0, 4'b0000, 0, rd, er);
        chk("oob_ld_err", 32'(er), 32'd1);
        chk("oob_ld_rdata", rd, 32'd0);
        txn(1'b1, BASE + 32'd4096, 32'h12345678, 4'b1111, 1, rd, er);
        chk("oob_st_err", 32'(er), 32'd1);
        txn(1'b0, BASE, 32'd0, 4'b0000, 0, rd, er);
        chk("oob_word0", rd, 32'hCAFEF00D);
        txn(1'b0, BASE + 32'd4092, 32'd0, 4'b0000, 0, rd, er);
        chk("last_word_err", 32'(er), 32'd0);

        // Alignment
        txn(1'b0, 32'h13, 32'd0, 4'b0000, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("align_err", 32'(er), 32'd1);
        chk("align_rdata", rd, 32'd0);
`else
        chk("align_err", 32'(er), 32'd0);
        chk("align_rdata", rd, 32'hDEADBEEF);
`endif

        // Reset during WAIT discards the pending store
        txn(1'b1, 32'h30, 32'h01010101, 4'b1111, 0, rd, er);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h5A5A5A5A;
        req_be    = 4'b1111;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h30, 32'd0, 4'b0000, 0, rd, er);
        chk("midrst_data", rd, 32'h01010101);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            wd = $urandom_range(0, 63);
            a  = BASE + 32'(wd * 4);
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = BASE + 32'd4096 + 32'($urandom_range(0, 1000) * 4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
